spis_qpimem_wr_arb: RTL and testbench

//  Round-robin arbiter sharing one qpimem_arb DMA write port between N_REQ burst writers
//  (SPI-slave write FIFOs, future DMA engines). Grants whole bursts only, never preempts.

---
 rtl/spis_arb_pkg.sv | 11 +
 rtl/spis_qpimem_wr_arb_if.sv | 23 ++
 rtl/spis_rr_pick.sv | 30 +++
 rtl/spis_qpimem_wr_arb.sv | 102 ++++++++++
 tb/tb_spis_qpimem_wr_arb.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/spis_arb_pkg.sv
// Shared types for the qpimem write-port arbiter: FSM state encoding and owner index sizing.
package spis_arb_pkg;
    localparam int MAX_REQ = 8;
    localparam int OWNER_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TAIL  = 2'd2
    } state_t;
endpackage

// File: rtl/spis_qpimem_wr_arb_if.sv
// Bus bundle between the burst writers, the arbiter and qpimem_arb's DMA write port.
interface spis_qpimem_wr_arb_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    req_do_write;
    logic [32*N_REQ-1:0] req_addr;
    logic [32*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]    req_next_word;
    logic                arb_do_write;
    logic                arb_next_word;
    logic [31:0]         arb_addr;
    logic [31:0]         arb_wdata;

    // master: the arbiter itself; slave: writers plus qpimem_arb as seen from outside
    modport master (
        input  req_do_write, req_addr, req_wdata, arb_next_word,
        output req_next_word, arb_do_write, arb_addr, arb_wdata
    );
    modport slave (
        output req_do_write, req_addr, req_wdata, arb_next_word,
        input  req_next_word, arb_do_write, arb_addr, arb_wdata
    );
endinterface

// File: rtl/spis_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N_REQ.
module spis_rr_pick
    import spis_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               valid,
    output logic [OWNER_W-1:0] idx
);
    logic [2*N_REQ-1:0] rot;
    logic [OWNER_W:0]   sum;

    always_comb begin
        // rotate so that bit 0 of rot is the requester at ptr
        rot   = {req, req} >> ptr;
        valid = |req;
        idx   = '0;
        sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (OWNER_W + 1)'(k);
                if (sum >= (OWNER_W + 1)'(N_REQ))
                    sum = sum - (OWNER_W + 1)'(N_REQ);
                idx = sum[OWNER_W-1:0];
            end
        end
    end
endmodule

// File: rtl/spis_qpimem_wr_arb.sv
// Round-robin arbiter sharing one qpimem_arb write port between N_REQ burst writers.
// Optional tail watchdog enabled by defining SPIS_ARB_WATCHDOG_EN.
module spis_qpimem_wr_arb
    import spis_arb_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int TAIL_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spis_qpimem_wr_arb_if.master bus,
    output logic                 busy,
    output logic [OWNER_W-1:0]   owner,
    output logic                 wd_error
);
    if (N_REQ < 2 || N_REQ > MAX_REQ || TAIL_TIMEOUT < 1) begin : g_bad_param
        $error("spis_qpimem_wr_arb: N_REQ must be 2..%0d and TAIL_TIMEOUT >= 1", MAX_REQ);
    end

    state_t             state, state_nx;
    logic [OWNER_W-1:0] rr_ptr;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_valid;
    logic [N_REQ-1:0]   owner_mask;
    logic               owner_dw;
    logic               wd_fire;

    spis_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req_do_write),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_mask = N_REQ'(1) << owner;
    assign owner_dw   = |(bus.req_do_write & owner_mask);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_valid) begin
                owner  <= pick_idx;
                rr_ptr <= (pick_idx == OWNER_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_valid) state_nx = GRANT;
            // owner done: a next_word in the same cycle is the tail, otherwise wait for it
            GRANT:   if (!owner_dw) state_nx = bus.arb_next_word ? IDLE : TAIL;
            TAIL:    if (bus.arb_next_word || wd_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.arb_do_write  = 1'b0;
        bus.arb_addr      = '0;
        bus.arb_wdata     = '0;
        bus.req_next_word = '0;
        if (state != IDLE) begin
            bus.arb_do_write  = owner_dw;
            bus.req_next_word = N_REQ'(bus.arb_next_word) << owner;
            for (int i = 0; i < N_REQ; i++) begin
                if (owner == OWNER_W'(i)) begin
                    bus.arb_addr  = bus.req_addr[32*i +: 32];
                    bus.arb_wdata = bus.req_wdata[32*i +: 32];
                end
            end
        end
    end

`ifdef SPIS_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TAIL_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    // fires on the TAIL_TIMEOUT-th TAIL cycle; the missing next_word is simply dropped
    assign wd_fire = (state == TAIL) && !bus.arb_next_word
                     && (wd_cnt == WD_W'(TAIL_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt   <= '0;
            wd_error <= 1'b0;
        end else begin
            wd_cnt <= (state == TAIL) ? wd_cnt + 1'b1 : '0;
            if (wd_fire) wd_error <= 1'b1;
        end
    end
`else
    assign wd_fire  = 1'b0;
    assign wd_error = 1'b0;
`endif
endmodule

// File: tb/tb_spis_qpimem_wr_arb.sv
// Directed bench for spis_qpimem_wr_arb (N_REQ=2, TAIL_TIMEOUT=16); honours SPIS_ARB_WATCHDOG_EN.
module tb_spis_qpimem_wr_arb;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       busy;
    logic [2:0] owner;
    logic       wd_error;

    int n_chk  = 0;
    int n_fail = 0;
    int nw0_cnt = 0;
    int both_cnt = 0;
    int base0;
    logic [1:0] m;
    logic [2:0] exp_own;

    spis_qpimem_wr_arb_if #(.N_REQ(2)) bus ();

    spis_qpimem_wr_arb #(.N_REQ(2), .TAIL_TIMEOUT(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .busy     (busy),
        .owner    (owner),
        .wd_error (wd_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.req_next_word[0]) nw0_cnt++;
        if (&bus.req_next_word) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.req_do_write  = 2'b00;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.arb_next_word = 1'b0;

        // reset state, with a request pending while reset is held
        tick();
        bus.req_do_write = 2'b01;
        bus.arb_next_word = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_dw", 32'(bus.arb_do_write), 0);
        chk("rst_nw", 32'(bus.req_next_word), 0);
        chk("rst_wd", 32'(wd_error), 0);
        bus.req_do_write = 2'b00;
        bus.arb_next_word = 1'b0;
        reset_n = 1'b1;
        tick();

        // T1: single req0 burst of 4 words, next_word every other cycle
        bus.req_addr[31:0]  = 32'h1000;
        bus.req_wdata[31:0] = 32'hA0;
        bus.req_do_write    = 2'b01;
        #1 chk("t1_lat_dw", 32'(bus.arb_do_write), 0);
        chk("t1_lat_busy", 32'(busy), 0);
        tick();
        chk("t1_grant_busy", 32'(busy), 1);
        chk("t1_grant_owner", 32'(owner), 0);
        chk("t1_grant_dw", 32'(bus.arb_do_write), 1);
        chk("t1_grant_wdata", bus.arb_wdata, 32'hA0);
        base0 = nw0_cnt;
        for (int w = 0; w < 4; w++) begin
            tick();
            if (w == 3) begin
                chk("t1_tail_busy", 32'(busy), 1);
                chk("t1_tail_dw", 32'(bus.arb_do_write), 0);
            end
            bus.arb_next_word = 1'b1;
            #1 chk("t1_nw_route", 32'(bus.req_next_word), 1);
            chk("t1_addr", bus.arb_addr, 32'h1000 + 32'(4 * w));
            tick();
            bus.arb_next_word = 1'b0;
            bus.req_addr[31:0]  = bus.req_addr[31:0] + 32'd4;
            bus.req_wdata[31:0] = bus.req_wdata[31:0] + 32'd1;
            if (w == 2) bus.req_do_write = 2'b00;
        end
        chk("t1_idle", 32'(busy), 0);
        chk("t1_pulses", 32'(nw0_cnt - base0), 4);

        // T2: both request at reset exit; strict alternation over 4 bursts
        reset_n = 1'b0;
        tick();
        bus.req_do_write = 2'b11;
        bus.req_addr     = {32'h2000, 32'h1000};
        reset_n = 1'b1;
        both_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            m       = (b % 2 == 0) ? 2'b01 : 2'b10;
            exp_own = (b % 2 == 0) ? 3'd0 : 3'd1;
            tick();
            chk("t2_owner", 32'(owner), 32'(exp_own));
            chk("t2_addr", bus.arb_addr, (b % 2 == 0) ? 32'h1000 : 32'h2000);
            bus.arb_next_word = 1'b1;
            #1 chk("t2_nw_body", 32'(bus.req_next_word), 32'(m));
            tick();
            bus.arb_next_word = 1'b0;
            bus.req_do_write = bus.req_do_write & ~m;
            tick();
            bus.arb_next_word = 1'b1;
            #1 chk("t2_nw_tail", 32'(bus.req_next_word), 32'(m));
            tick();
            bus.arb_next_word = 1'b0;
            bus.req_do_write = bus.req_do_write | m;
            chk("t2_gap_idle", 32'(busy), 0);
        end
        bus.req_do_write = 2'b00;
        chk("t2_no_overlap", 32'(both_cnt), 0);
        tick();

        // T3: req1 arrives mid req0 burst and waits for req0's tail
        bus.req_do_write = 2'b01;
        tick();
        chk("t3_owner0", 32'(owner), 0);
        bus.arb_next_word = 1'b1;
        tick();
        bus.arb_next_word = 1'b0;
        bus.req_do_write = 2'b11;
        tick();
        chk("t3_hold_owner", 32'(owner), 0);
        chk("t3_hold_addr", bus.arb_addr, 32'h1000);
        bus.req_do_write = 2'b10;
        tick();
        chk("t3_tail_busy", 32'(busy), 1);
        chk("t3_tail_owner", 32'(owner), 0);
        bus.arb_next_word = 1'b1;
        #1 chk("t3_tail_nw", 32'(bus.req_next_word), 1);
        tick();
        bus.arb_next_word = 1'b0;
        chk("t3_idle", 32'(busy), 0);
        tick();
        chk("t3_owner1", 32'(owner), 1);
        chk("t3_addr1", bus.arb_addr, 32'h2000);

        // T4: drop do_write with next_word in the same cycle, then a stray next_word in IDLE
        bus.req_do_write = 2'b00;
        bus.arb_next_word = 1'b1;
        #1 chk("t4_nw", 32'(bus.req_next_word), 2);
        tick();
        chk("t4_direct_idle", 32'(busy), 0);
        #1 chk("t4_stray_nw", 32'(bus.req_next_word), 0);
        chk("t4_stray_dw", 32'(bus.arb_do_write), 0);
        tick();
        bus.arb_next_word = 1'b0;
        chk("t4_still_idle", 32'(busy), 0);

        // T5: reset at word 3 of 8; afterwards the pointer restarts at 0
        bus.req_addr[31:0] = 32'h3000;
        bus.req_do_write = 2'b01;
        tick();
        chk("t5_owner0", 32'(owner), 0);
        for (int w = 0; w < 2; w++) begin
            bus.arb_next_word = 1'b1;
            tick();
            bus.arb_next_word = 1'b0;
        end
        bus.req_do_write = 2'b11;
        bus.arb_next_word = 1'b1;
        reset_n = 1'b0;
        #1 chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_dw", 32'(bus.arb_do_write), 0);
        chk("t5_rst_addr", bus.arb_addr, 0);
        chk("t5_rst_nw", 32'(bus.req_next_word), 0);
        tick();
        bus.arb_next_word = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("t5_regrant_owner", 32'(owner), 0);
        chk("t5_regrant_busy", 32'(busy), 1);
        bus.req_do_write = 2'b00;
        bus.arb_next_word = 1'b1;
        tick();
        bus.arb_next_word = 1'b0;

        // T6: withhold the tail next_word
        bus.req_do_write = 2'b01;
        tick();
        bus.req_do_write = 2'b00;
        tick();
        for (int i = 1; i < 16; i++) tick();
        chk("t6_tail16_busy", 32'(busy), 1);
        tick();
`ifdef SPIS_ARB_WATCHDOG_EN
        chk("t6_wd_idle", 32'(busy), 0);
        chk("t6_wd_error", 32'(wd_error), 1);
        tick();
        chk("t6_wd_sticky", 32'(wd_error), 1);
`else
        chk("t6_no_wd_busy", 32'(busy), 1);
        chk("t6_no_wd_error", 32'(wd_error), 0);
        bus.arb_next_word = 1'b1;
        #1 chk("t6_late_nw", 32'(bus.req_next_word), 1);
        tick();
        bus.arb_next_word = 1'b0;
        chk("t6_late_idle", 32'(busy), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
